pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous square/PWM
// input in clk cycles, with a stuck-input watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no reference rising edge yet (after reset or after a timeout)
//   HIGH  | input high since the last rising edge, waiting for the fall
//   LOW   | input low after the fall, waiting for the rise that closes the period
//
// The rise in LOW publishes period/high_time with a one-cycle valid pulse.
// A timeout in HIGH or LOW sets stuck and drops back to IDLE. The next
// rise clears stuck, but only acts as a new reference edge. This means a
// full period must elapse before the next valid.
module pwm_capture #(
    parameter int CNT_WIDTH = 26,
    parameter int TIMEOUT   = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 rise;
    logic                 fall;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] high_cand;

    logic                 timeout;
    logic                 latch_high;
    logic                 capture;

    // Bring sig_in into the clk domain and keep one extra flop of history
    // for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes. In HIGH, the timeout takes precedence
    // over a coincident fall: the measurement is abandoned in that cycle.
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        latch_high = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (!rise && (cnt == TIMEOUT_CNT)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (fall) begin
                    latch_high = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    capture    = 1'b1;
                    state_next = HIGH;
                end else if (cnt == TIMEOUT_CNT) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Cycles since the last rise. The count restarts at 1 on every rise
    // and saturates instead of wrapping so a long-stuck input cannot alias
    // back onto a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Hold the high-phase length until the closing rise publishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cand <= '0;
        end else if (latch_high) begin
            high_cand <= cnt;
        end
    end

    // Published measurement. Both values move only together with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                period    <= cnt;
                high_time <= high_cand;
            end
        end
    end

    // Stuck flag and the input level at the time it was set. Any rise
    // clears the flag, including the rise out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (rise) begin
            stuck <= 1'b0;
        end else if (timeout) begin
            stuck       <= 1'b1;
            stuck_level <= s2;
        end
    end

endmodule
